// File: rtl/flag_registers.sv
// Four-bit condition-flag register (Z, N, V, C) for the pipelined CPU.
// Each flag is a 2:1 mux (load vs. hold) feeding an async-reset D flip-flop.

module mux_2_1 (
  input  logic       select,
  input  logic [1:0] load,
  output logic       out
);

  assign out = select ? load[1] : load[0];

endmodule


module D_FF (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= 1'b0;
    else
      q <= d;
  end

endmodule


module flag_registers (
  input  logic clk,
  input  logic reset,
  input  logic setflags,
  input  logic zero,
  input  logic negative,
  input  logic overflow,
  input  logic carry_out,
  output logic zeroReg,
  output logic negativeReg,
  output logic overflReg,
  output logic carry_oReg
);

  // Bit order throughout is {Z, N, V, C}; all four share one select so
  // a load is never partial.
  logic [3:0] flag_in;
  logic [3:0] flag_d;
  logic [3:0] flag_q;

  assign flag_in = {zero, negative, overflow, carry_out};

  for (genvar i = 0; i < 4; i++) begin : g_flag
    mux_2_1 u_mux (
      .select (setflags),
      .load   ({flag_in[i], flag_q[i]}),
      .out    (flag_d[i])
    );

    D_FF u_ff (
      .clk   (clk),
      .reset (reset),
      .d     (flag_d[i]),
      .q     (flag_q[i])
    );
  end

  assign zeroReg     = flag_q[3];
  assign negativeReg = flag_q[2];
  assign overflReg   = flag_q[1];
  assign carry_oReg  = flag_q[0];

endmodule

// File: tb/tb_flag_registers.sv
// Directed self-checking bench for flag_registers.
// Flags are handled as a 4-bit vector in {Z, N, V, C} order.

module tb_flag_registers;

  logic clk = 1'b0;
  logic reset;
  logic setflags;
  logic zero;
  logic negative;
  logic overflow;
  logic carry_out;
  logic zeroReg;
  logic negativeReg;
  logic overflReg;
  logic carry_oReg;

  int checks = 0;
  int errors = 0;

  flag_registers dut (
    .clk         (clk),
    .reset       (reset),
    .setflags    (setflags),
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .carry_out   (carry_out),
    .zeroReg     (zeroReg),
    .negativeReg (negativeReg),
    .overflReg   (overflReg),
    .carry_oReg  (carry_oReg)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic sf, input logic [3:0] f);
    setflags = sf;
    {zero, negative, overflow, carry_out} = f;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    reset = 1'b1;
    drive(1'b0, 4'b0000);
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected 0000", obs);
    end
  endtask

  task automatic test_hold_after_reset;
    logic [3:0] obs;
    reset = 1'b0;
    drive(1'b0, 4'b0110);
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL hold_after_reset: got %b expected 0000", obs);
    end
  endtask

  task automatic test_load;
    logic [3:0] obs;
    drive(1'b1, 4'b0110);
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL load_nv: got %b expected 0110", obs);
    end
  endtask

  task automatic test_hold_after_load;
    logic [3:0] obs;
    drive(1'b0, 4'b0000);
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL hold_after_load: got %b expected 0110", obs);
    end
    // Inputs changing between edges must not reach the outputs.
    drive(1'b1, 4'b1001);
    #2;
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL no_comb_path: got %b expected 0110", obs);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] obs;
    drive(1'b1, 4'b1001);
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL load_zc: got %b expected 1001", obs);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected 0000", obs);
    end
    reset = 1'b0;
    #1;
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL after_reset_pulse: got %b expected 0000", obs);
    end
  endtask

  task automatic test_reset_dominates;
    logic [3:0] obs;
    drive(1'b1, 4'b1111);
    reset = 1'b1;
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_dominates: got %b expected 0000", obs);
    end
    reset = 1'b0;
    tick();
    obs = {zeroReg, negativeReg, overflReg, carry_oReg};
    checks++;
    if (obs !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL first_load_after_reset: got %b expected 1111", obs);
    end
  endtask

  // Every flag combination loaded back-to-back, each followed by a hold
  // cycle with inverted inputs.
  task automatic test_back_to_back;
    logic [3:0] obs;
    logic [3:0] pat;
    for (int i = 0; i < 16; i++) begin
      pat = 4'(i);
      drive(1'b1, pat);
      tick();
      obs = {zeroReg, negativeReg, overflReg, carry_oReg};
      checks++;
      if (obs !== pat) begin
        errors++;
        $display("[TB] FAIL pattern_load %0d: got %b expected %b", i, obs, pat);
      end
      drive(1'b0, ~pat);
      tick();
      obs = {zeroReg, negativeReg, overflReg, carry_oReg};
      checks++;
      if (obs !== pat) begin
        errors++;
        $display("[TB] FAIL pattern_hold %0d: got %b expected %b", i, obs, pat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_after_reset();
    test_load();
    test_hold_after_load();
    test_async_reset();
    test_reset_dominates();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
